// File: rtl/timer_pkg.sv
// Shared state encoding, time field slices and blink masks
// for the mm:ss countdown timer.
package timer_pkg;

    typedef enum logic [2:0] {
        EDIT_MIN = 3'd0,
        EDIT_SEC = 3'd1,
        RUN      = 3'd2,
        PAUSE    = 3'd3,
        ALERT    = 3'd4
    } state_t;

    localparam int MIN10_HI = 14;
    localparam int MIN10_LO = 12;
    localparam int MIN1_HI  = 11;
    localparam int MIN1_LO  = 8;
    localparam int SEC10_HI = 6;
    localparam int SEC10_LO = 4;
    localparam int SEC1_HI  = 3;
    localparam int SEC1_LO  = 0;

    localparam logic [3:0] MASK_MIN  = 4'b1100;
    localparam logic [3:0] MASK_SEC  = 4'b0011;
    localparam logic [3:0] MASK_ALL  = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    function automatic logic [3:0] blink_mask(input state_t s);
        logic [3:0] m;
        m = MASK_NONE;
        unique case (s)
            EDIT_MIN: m = MASK_MIN;
            EDIT_SEC: m = MASK_SEC;
            ALERT:    m = MASK_ALL;
            default:  m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled and
// flags the terminal count combinationally.
module tick_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_sequencer.sv
// Countdown timer control FSM: edit/run/pause/alert sequencing,
// BCD counter strobes and 7-segment blink masks.
module countdown_sequencer
    import timer_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int ALERT_SECS = 10,
    parameter int BLINK_DIV  = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_start,
    input  logic        btn_off,
    input  logic [15:0] time_bcd,
    output logic        min_up,
    output logic        sec_up,
    output logic        min_dec,
    output logic        sec_dec,
    output logic        sec_load59,
    output logic        clr,
    output logic        alert,
    output logic [3:0]  blank_mask,
    output logic [2:0]  state
);

    localparam int AW = (ALERT_SECS > 1) ? $clog2(ALERT_SECS) : 1;

    state_t cur, nxt;
    logic   tick, btick, phase, changed;
    logic   time_zero, sec_zero, strobe_q, alert_last;
    logic   presc_en, presc_clr, is_edit;
    logic   n_min_up, n_sec_up, n_min_dec, n_sec_dec;
    logic   n_load59, n_clr;
    logic [AW-1:0] alert_cnt;

    assign time_zero  = (time_bcd == 16'h0000);
    assign sec_zero   = (time_bcd[SEC10_HI:SEC1_LO] == '0);
    assign strobe_q   = min_up | sec_up | min_dec | sec_dec
                      | sec_load59 | clr;
    assign alert_last = (alert_cnt == AW'(ALERT_SECS - 1));
    assign is_edit    = (cur == EDIT_MIN) || (cur == EDIT_SEC);
    assign presc_en   = (cur == RUN) || (cur == ALERT);
    // Entering ALERT restarts the count so silence timing starts fresh.
    assign presc_clr  = is_edit || (nxt == ALERT && cur != ALERT);
    assign changed    = (nxt != cur);

    tick_prescaler #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    tick_prescaler #(.DIV(BLINK_DIV)) u_blink (
        .clk  (clk),
        .reset(reset),
        .en   (1'b1),
        .clr  (changed),
        .tick (btick)
    );

    always_comb begin
        nxt       = cur;
        n_min_up  = 1'b0;
        n_sec_up  = 1'b0;
        n_min_dec = 1'b0;
        n_sec_dec = 1'b0;
        n_load59  = 1'b0;
        n_clr     = 1'b0;
        unique case (cur)
            EDIT_MIN, EDIT_SEC: begin
                if (btn_off) begin
                    n_clr = 1'b1;
                end else if (btn_start) begin
                    if (!time_zero) nxt = RUN;
                end else if (btn_mode) begin
                    nxt = (cur == EDIT_MIN) ? EDIT_SEC : EDIT_MIN;
                end else if (btn_up) begin
                    n_min_up = (cur == EDIT_MIN);
                    n_sec_up = (cur == EDIT_SEC);
                end
            end
            RUN: begin
                if (btn_off) begin
                    n_clr = 1'b1;
                    nxt   = EDIT_MIN;
                end else if (time_zero && !strobe_q) begin
                    // A strobe in flight means time_bcd is still stale.
                    nxt = ALERT;
                end else begin
                    if (btn_start) nxt = PAUSE;
                    if (tick) begin
                        if (!sec_zero) begin
                            n_sec_dec = 1'b1;
                        end else if (!time_zero) begin
                            n_min_dec = 1'b1;
                            n_load59  = 1'b1;
                        end
                    end
                end
            end
            PAUSE: begin
                if (btn_off) begin
                    n_clr = 1'b1;
                    nxt   = EDIT_MIN;
                end else if (btn_start) begin
                    nxt = RUN;
                end else if (btn_mode) begin
                    nxt = EDIT_MIN;
                end
            end
            ALERT: begin
                if (btn_off || (tick && alert_last)) nxt = EDIT_MIN;
            end
            default: nxt = EDIT_MIN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= EDIT_MIN;
            min_up     <= 1'b0;
            sec_up     <= 1'b0;
            min_dec    <= 1'b0;
            sec_dec    <= 1'b0;
            sec_load59 <= 1'b0;
            clr        <= 1'b0;
            alert_cnt  <= '0;
            phase      <= 1'b0;
        end else begin
            cur        <= nxt;
            min_up     <= n_min_up;
            sec_up     <= n_sec_up;
            min_dec    <= n_min_dec;
            sec_dec    <= n_sec_dec;
            sec_load59 <= n_load59;
            clr        <= n_clr;
            if (cur != ALERT) alert_cnt <= '0;
            else if (tick)    alert_cnt <= alert_cnt + 1'b1;
            if (changed)    phase <= 1'b0;
            else if (btick) phase <= ~phase;
        end
    end

    assign alert      = (cur == ALERT);
    assign state      = cur;
    assign blank_mask = phase ? blink_mask(cur) : MASK_NONE;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer with a BCD counter
// environment and a cycle-level reference model.
`timescale 1ns/1ps
module tb_countdown_sequencer;

    localparam int TD = 4;
    localparam int AS = 3;
    localparam int BD = 2;

    localparam logic [5:0] S_MINUP = 6'b100000;
    localparam logic [5:0] S_SECUP = 6'b010000;
    localparam logic [5:0] S_MDEC  = 6'b001010;
    localparam logic [5:0] S_SDEC  = 6'b000100;
    localparam logic [5:0] S_CLR   = 6'b000001;

    localparam int M_EMIN  = 0;
    localparam int M_ESEC  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_ALERT = 4;

    typedef struct packed {
        logic [5:0] strb;
        logic       alrt;
        logic [3:0] blank;
        logic [2:0] st;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 1'b0, btn_up = 1'b0;
    logic        btn_start = 1'b0, btn_off = 1'b0;
    logic [15:0] time_bcd;
    logic        min_up, sec_up, min_dec, sec_dec;
    logic        sec_load59, clr, alert;
    logic [3:0]  blank_mask;
    logic [2:0]  state;

    int n_chk = 0;
    int n_err = 0;

    int t_min = 0, t_sec = 0;
    int ov_min = -1, ov_sec = 0;
    logic [5:0] pend = '0;

    int m_st, m_pre, m_ati, m_bcnt;
    bit m_ph;
    logic [5:0] m_strb;

    snap_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int m, input int s);
        logic [15:0] v;
        v = '0;
        v[14:12] = 3'(m / 10);
        v[11:8]  = 4'(m % 10);
        v[6:4]   = 3'(s / 10);
        v[3:0]   = 4'(s % 10);
        return v;
    endfunction

    assign time_bcd = to_bcd(t_min, t_sec);

    countdown_sequencer #(
        .TICK_DIV  (TD),
        .ALERT_SECS(AS),
        .BLINK_DIV (BD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_start (btn_start),
        .btn_off   (btn_off),
        .time_bcd  (time_bcd),
        .min_up    (min_up),
        .sec_up    (sec_up),
        .min_dec   (min_dec),
        .sec_dec   (sec_dec),
        .sec_load59(sec_load59),
        .clr       (clr),
        .alert     (alert),
        .blank_mask(blank_mask),
        .state     (state)
    );

    function automatic snap_t dut_snap();
        snap_t a;
        a.strb  = {min_up, sec_up, min_dec, sec_dec, sec_load59, clr};
        a.alrt  = alert;
        a.blank = blank_mask;
        a.st    = state;
        return a;
    endfunction

    function automatic snap_t model_snap();
        snap_t e;
        logic [3:0] mk;
        mk = 4'b0000;
        if (m_st == M_EMIN)  mk = 4'b1100;
        if (m_st == M_ESEC)  mk = 4'b0011;
        if (m_st == M_ALERT) mk = 4'b1111;
        e.strb  = m_strb;
        e.alrt  = (m_st == M_ALERT);
        e.blank = m_ph ? mk : 4'b0000;
        e.st    = 3'(m_st);
        return e;
    endfunction

    task automatic model_reset();
        m_st = M_EMIN; m_pre = 0; m_ati = 0;
        m_bcnt = 0; m_ph = 0; m_strb = '0;
    endtask

    // One clock edge of the reference behaviour, seen from
    // the inputs that edge samples.
    task automatic model_step(input bit bo, bs, bm, bu);
        int nx;
        bit tk, zero, sec0;
        logic [5:0] s;
        nx = m_st;
        s = '0;
        zero = (t_min == 0) && (t_sec == 0);
        sec0 = (t_sec == 0);
        tk = (m_st == M_RUN || m_st == M_ALERT) && (m_pre == TD - 1);
        if (m_st == M_EMIN || m_st == M_ESEC) begin
            if (bo) s = S_CLR;
            else if (bs) begin
                if (!zero) nx = M_RUN;
            end
            else if (bm) nx = (m_st == M_EMIN) ? M_ESEC : M_EMIN;
            else if (bu) s = (m_st == M_EMIN) ? S_MINUP : S_SECUP;
        end else if (m_st == M_RUN) begin
            if (bo) begin
                s = S_CLR; nx = M_EMIN;
            end else if (zero && m_strb == 0) begin
                nx = M_ALERT;
            end else begin
                if (bs) nx = M_PAUSE;
                if (tk && !sec0) s = S_SDEC;
                else if (tk && !zero) s = S_MDEC;
            end
        end else if (m_st == M_PAUSE) begin
            if (bo) begin
                s = S_CLR; nx = M_EMIN;
            end
            else if (bs) nx = M_RUN;
            else if (bm) nx = M_EMIN;
        end else begin
            if (bo || (tk && m_ati == AS - 1)) nx = M_EMIN;
        end
        if (m_st <= M_ESEC || (nx == M_ALERT && m_st != M_ALERT))
            m_pre = 0;
        else if (m_st == M_RUN || m_st == M_ALERT)
            m_pre = (m_pre + 1) % TD;
        if (m_st != M_ALERT) m_ati = 0;
        else if (tk) m_ati = m_ati + 1;
        if (nx != m_st) begin
            m_bcnt = 0; m_ph = 0;
        end else begin
            m_bcnt = m_bcnt + 1;
            if (m_bcnt == BD) begin
                m_bcnt = 0; m_ph = !m_ph;
            end
        end
        m_strb = s;
        m_st = nx;
    endtask

    // BCD counter environment: strobes take effect the next cycle.
    task automatic apply_env(input logic [5:0] p);
        if (p[0]) begin t_min = 0; t_sec = 0; end
        if (p[5]) t_min = (t_min + 1) % 60;
        if (p[4]) t_sec = (t_sec + 1) % 60;
        if (p[3]) t_min = (t_min + 59) % 60;
        if (p[2]) t_sec = (t_sec + 59) % 60;
        if (p[1]) t_sec = 59;
    endtask

    task automatic set_time(input int m, input int s);
        ov_min = m; ov_sec = s;
    endtask

    task automatic cyc(input bit bo, bs, bm, bu);
        @(posedge clk);
        #1;
        apply_env(pend);
        if (ov_min >= 0) begin
            t_min = ov_min; t_sec = ov_sec; ov_min = -1;
        end
        exp_q.push_back(model_snap());
        pend = {min_up, sec_up, min_dec, sec_dec, sec_load59, clr};
        btn_off = bo; btn_start = bs; btn_mode = bm; btn_up = bu;
        model_step(bo, bs, bm, bu);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        model_reset();
        model_step(0, 0, 0, 0);
    endtask

    task automatic mid_reset();
        logic [11:0] got;
        @(negedge clk);
        #1;
        reset = 1'b1;
        btn_off = 0; btn_start = 0; btn_mode = 0; btn_up = 0;
        #1;
        got = {min_up, sec_up, min_dec, sec_dec, sec_load59,
               clr, alert, blank_mask};
        n_chk++;
        if (got != '0 || state != 3'd0) begin
            n_err++;
            $display("FAIL async_reset outs=%b state=%0d want 0/0",
                     got, state);
        end
        pend = '0; t_min = 0; t_sec = 0; ov_min = -1;
        @(negedge clk);
        #1;
        release_reset();
    endtask

    always @(negedge clk) begin
        snap_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_snap();
            n_chk++;
            if (a !== e) begin
                n_err++;
                if (n_err <= 30)
                    $display("FAIL cycle t=%0t strb=%b/%b alert=%b/%b blank=%b/%b state=%0d/%0d (act/exp)",
                             $time, a.strb, e.strb, a.alrt, e.alrt,
                             a.blank, e.blank, a.st, e.st);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        release_reset();

        // edit: minute and second increments with blink
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 1);
        idle(6);

        // start rejected at 00:00
        cyc(1, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0);
        idle(20);

        // minute borrow then seconds countdown
        set_time(1, 0);
        cyc(0, 1, 0, 0);
        idle(12);
        cyc(1, 0, 0, 0);
        idle(3);

        // expiry with auto-silence, then early silence
        set_time(0, 1);
        cyc(0, 1, 0, 0);
        idle(22);
        set_time(0, 1);
        cyc(0, 1, 0, 0);
        idle(9);
        cyc(1, 0, 0, 0);
        idle(4);

        // pause two cycles after a tick, resume
        set_time(0, 30);
        cyc(0, 1, 0, 0);
        idle(5);
        cyc(0, 1, 0, 0);
        idle(10);
        cyc(0, 1, 0, 0);
        idle(8);

        // pause, off+start together, then reset mid-run
        cyc(0, 1, 0, 0);
        idle(3);
        cyc(1, 1, 0, 0);
        idle(3);
        set_time(0, 40);
        cyc(0, 1, 0, 0);
        idle(6);
        mid_reset();
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            int r;
            bit bo, bs, bm, bu;
            r = $urandom_range(0, 999);
            bo = 0; bs = 0; bm = 0; bu = 0;
            if (r == 0) begin
                mid_reset();
            end else begin
                if (m_st <= M_ESEC && $urandom_range(0, 19) == 0)
                    set_time($urandom_range(0, 1),
                             $urandom_range(0, 12));
                r = $urandom_range(0, 99);
                if (r < 3) {bo, bs, bm, bu} = 4'($urandom_range(1, 15));
                else if (r < 5)  bo = 1;
                else if (r < 10) bs = 1;
                else if (r < 14) bm = 1;
                else if (r < 22) bu = 1;
                cyc(bo, bs, bm, bu);
            end
        end
        idle(2);

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
